// File: rtl/data_ram_be.sv
// Byte-addressed data memory for the MEM stage: byte/half/word(/double) loads and stores,
// sign/zero-extended loads, misalignment flagging and a post-reset clear sweep.
module data_ram_be #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int OB            = $clog2(DATA_WIDTH / 8)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic                     we,
    input  logic [ADDR_WIDTH+OB-1:0] addr,
    input  logic [1:0]               size,
    input  logic                     uns,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     misalign,
    output logic                     ready
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LW    = $clog2(DATA_WIDTH);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic [ADDR_WIDTH-1:0]   ptr_d;
    logic                    ready_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH] = '{default: '0};

    logic [ADDR_WIDTH-1:0]   widx;
    logic [OB-1:0]           off;
    logic [OB-1:0]           off_mask;
    logic [NB-1:0]           be;
    logic [DATA_WIDTH-1:0]   wd_sh;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   shifted;
    logic [LW-1:0]           msb_idx;
    logic                    sign_bit;
    logic [DATA_WIDTH-1:0]   rdata_c;
    logic                    clr_en;
    logic                    store_en;
    logic                    load_en;

    assign widx = addr[ADDR_WIDTH+OB-1:OB];
    assign off  = addr[OB-1:0];

    // Offset bits below log2(size) must be zero for a naturally aligned access.
    always_comb begin
        off_mask = '0;
        for (int b = 0; b < OB; b++) begin
            off_mask[b] = (int'(size) > b);
        end
    end

    assign misalign = req & ((int'(size) > OB) | (|(off & off_mask)));

    assign clr_en   = (state_q == ST_CLEAR);
    assign store_en = (state_q == ST_READY) & req & we & ~misalign;
    assign load_en  = (state_q == ST_READY) & req & ~we & ~misalign;

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            be[b] = (b >= int'(off)) && (b < int'(off) + (1 << size));
        end
    end

    assign wd_sh = wdata << {off, 3'b000};

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[ptr_q] <= '0;
        end else if (store_en) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wd_sh[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[widx];

    // Align the addressed field to bit 0, then extend from its top bit.
    always_comb begin
        shifted  = rd_word >> {off, 3'b000};
        msb_idx  = LW'((8 << size) - 1);
        sign_bit = ~uns & shifted[msb_idx];
        rdata_c  = '0;
        if (load_en) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                rdata_c[i] = (i <= int'(msb_idx)) ? shifted[i] : sign_bit;
            end
        end
    end

    assign rdata = rdata_c;

    assign ptr_d = ptr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            ptr_q   <= '0;
            ready_q <= !CLEAR_ON_RESET;
        end else if (state_q == ST_CLEAR) begin
            ptr_q <= ptr_d;
            if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_q <= ST_READY;
                ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

endmodule
